systolic_feeder: RTL and testbench



---
 rtl/systolic_feeder_if.sv | 31 +++
 rtl/systolic_feeder.sv | 143 ++++++++++++++
 tb/tb_systolic_feeder.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/systolic_feeder_if.sv
// systolic_feeder_if: buffer write port, run control and array-edge lanes of the feeder.
// Ports: wr_en/wr_sel/wr_addr/wr_data load the A/B buffers; start/busy/done control a run;
//        a_out/b_out/mode_out drive the systolic array's left edge, top edge and PE mode line.
interface systolic_feeder_if #(
    parameter int N = 4,
    parameter int K = 4,
    parameter int W = 8
);
    localparam int AW = $clog2(K);

    logic            wr_en;
    logic            wr_sel;
    logic [AW-1:0]   wr_addr;
    logic [N*W-1:0]  wr_data;
    logic            start;
    logic            busy;
    logic            done;
    logic [N*W-1:0]  a_out;
    logic [N*W-1:0]  b_out;
    logic            mode_out;

    modport master (
        output wr_en, wr_sel, wr_addr, wr_data, start,
        input  busy, done, a_out, b_out, mode_out
    );

    modport slave (
        input  wr_en, wr_sel, wr_addr, wr_data, start,
        output busy, done, a_out, b_out, mode_out
    );
endinterface

// File: rtl/systolic_feeder.sv
// systolic_feeder: buffers K A-column / B-row vectors, then streams them skewed into an NxN
// systolic array, flushes with zeros and (with SYSTOLIC_FEEDER_DRAIN_EN) holds mode high to drain.
// Ports: clk, rst (sync, active-high), bus (systolic_feeder_if.slave). All outputs registered;
// first stream step appears one cycle after the start edge, done pulses as busy falls.
module systolic_feeder #(
    parameter int N = 4,
    parameter int K = 4,
    parameter int W = 8
) (
    input  logic               clk,
    input  logic               rst,
    systolic_feeder_if.slave   bus
);
    localparam int CW = $clog2(K + N + 1);
    localparam logic [CW-1:0] T_ONE         = CW'(1);
    // STREAM runs one extra step: step t shows skew slice t-1, so t=0 is the all-zero cycle 0.
    localparam logic [CW-1:0] T_STREAM_LAST = CW'(K + N - 1);
    localparam logic [CW-1:0] T_PHASE_LAST  = CW'(N - 1);

`ifdef SYSTOLIC_FEEDER_DRAIN_EN
    typedef enum logic [1:0] {IDLE, STREAM, FLUSH, DRAIN} state_t;
`else
    typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_t;
`endif

    state_t          state, state_nxt;
    logic [CW-1:0]   t, t_nxt;

    logic [N*W-1:0]  a_buf [K];
    logic [N*W-1:0]  b_buf [K];

    logic            busy_q, busy_nxt;
    logic            done_q, done_nxt;
    logic            mode_q, mode_nxt;
    logic [N*W-1:0]  a_q, a_nxt;
    logic [N*W-1:0]  b_q, b_nxt;

    // Buffer writes: out-of-range addresses match no entry; blocked for the whole run.
    // Not reset, so a run can be repeated after a reset without reloading.
    always_ff @(posedge clk) begin
        for (int k = 0; k < K; k++) begin
            if (bus.wr_en && !busy_q && int'(bus.wr_addr) == k) begin
                if (bus.wr_sel) b_buf[k] <= bus.wr_data;
                else            a_buf[k] <= bus.wr_data;
            end
        end
    end

    // Outputs are registered from the next state, so each edge presents the phase it enters.
    always_comb begin
        state_nxt = state;
        t_nxt     = t + T_ONE;
        done_nxt  = 1'b0;
        unique case (state)
            IDLE: begin
                t_nxt = '0;
                if (bus.start) state_nxt = STREAM;
            end
            STREAM: begin
                if (t == T_STREAM_LAST) begin
                    state_nxt = FLUSH;
                    t_nxt     = '0;
                end
            end
            FLUSH: begin
                if (t == T_PHASE_LAST) begin
                    t_nxt = '0;
`ifdef SYSTOLIC_FEEDER_DRAIN_EN
                    state_nxt = DRAIN;
`else
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
`endif
                end
            end
`ifdef SYSTOLIC_FEEDER_DRAIN_EN
            DRAIN: begin
                if (t == T_PHASE_LAST) begin
                    state_nxt = IDLE;
                    t_nxt     = '0;
                    done_nxt  = 1'b1;
                end
            end
`endif
            default: begin
                state_nxt = IDLE;
                t_nxt     = '0;
            end
        endcase

        busy_nxt = (state_nxt != IDLE);
`ifdef SYSTOLIC_FEEDER_DRAIN_EN
        mode_nxt = (state_nxt == DRAIN);
`else
        mode_nxt = 1'b0;
`endif

        // Diagonal skew: lane i carries vector (t-1-i) when that index is within 0..K-1.
        a_nxt = '0;
        b_nxt = '0;
        if (state_nxt == STREAM) begin
            for (int i = 0; i < N; i++) begin
                for (int k = 0; k < K; k++) begin
                    if (int'(t_nxt) - 1 - i == k) begin
                        a_nxt[i*W +: W] = a_buf[k][i*W +: W];
                        b_nxt[i*W +: W] = b_buf[k][i*W +: W];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            t      <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            mode_q <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
        end else begin
            state  <= state_nxt;
            t      <= t_nxt;
            busy_q <= busy_nxt;
            done_q <= done_nxt;
            mode_q <= mode_nxt;
            a_q    <= a_nxt;
            b_q    <= b_nxt;
        end
    end

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.a_out = a_q;
    assign bus.b_out = b_q;
`ifdef SYSTOLIC_FEEDER_DRAIN_EN
    assign bus.mode_out = mode_q;
`else
    // The external controller owns the PE mode line in this build.
    assign bus.mode_out = 1'b0;
`endif
endmodule

// File: tb/tb_systolic_feeder.sv
module tb_systolic_feeder;
    localparam int N = 4;
    localparam int K = 4;
    localparam int W = 8;
`ifdef SYSTOLIC_FEEDER_DRAIN_EN
    localparam int LAST     = K + 3*N;
    localparam bit DRAIN_ON = 1'b1;
`else
    localparam int LAST     = K + 2*N;
    localparam bit DRAIN_ON = 1'b0;
`endif

    typedef struct packed {
        logic           busy;
        logic           done;
        logic           mode;
        logic [N*W-1:0] a;
        logic [N*W-1:0] b;
    } obs_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    systolic_feeder_if #(.N(N), .K(K), .W(W)) bus();
    systolic_feeder #(.N(N), .K(K), .W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    obs_t           exp_q[$];
    obs_t           got, want;
    logic [N*W-1:0] ref_a [K];
    logic [N*W-1:0] ref_b [K];
    int             n_cmp = 0;
    int             n_bad = 0;

    task automatic chk(input string name, input logic [63:0] g, input logic [63:0] w);
        n_cmp++;
        if (g !== w) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, g, w);
        end
    endtask

    // Monitor: every cycle the feeder presents activity (busy or done) is scored.
    always @(negedge clk) begin
        if (!rst && (bus.busy || bus.done)) begin
            got = '{busy: bus.busy, done: bus.done, mode: bus.mode_out, a: bus.a_out, b: bus.b_out};
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_output: got busy=%b done=%b mode=%b a=%h b=%h, want none",
                         got.busy, got.done, got.mode, got.a, got.b);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    n_bad++;
                    $display("FAIL scoreboard: got busy=%b done=%b mode=%b a=%h b=%h want busy=%b done=%b mode=%b a=%h b=%h",
                             got.busy, got.done, got.mode, got.a, got.b,
                             want.busy, want.done, want.mode, want.a, want.b);
                end
            end
        end
    end

    function automatic logic [N*W-1:0] skew(input bit sel, input int c);
        logic [N*W-1:0] v;
        v = '0;
        if (c >= 1 && c <= K + N - 1) begin
            for (int i = 0; i < N; i++) begin
                int k;
                k = c - 1 - i;
                if (k >= 0 && k < K) v[i*W +: W] = sel ? ref_b[k][i*W +: W] : ref_a[k][i*W +: W];
            end
        end
        return v;
    endfunction

    task automatic push_run();
        obs_t e;
        for (int c = 0; c <= LAST; c++) begin
            e.busy = (c < LAST);
            e.done = (c == LAST);
            e.mode = DRAIN_ON && (c >= K + 2*N) && (c < K + 3*N);
            e.a    = skew(1'b0, c);
            e.b    = skew(1'b1, c);
            exp_q.push_back(e);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic write_vec(input bit sel, input int addr, input logic [N*W-1:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_sel  = sel;
        bus.wr_addr = addr[1:0];
        bus.wr_data = d;
        cyc();
        bus.wr_en = 1'b0;
        if (sel) ref_b[addr] = d;
        else     ref_a[addr] = d;
    endtask

    // kind: 0 plain, 1 skew spot checks, 2 writes/start during run, 3 write on the start edge
    task automatic do_run(input int kind);
        if (kind == 3) begin
            bus.wr_en   = 1'b1;
            bus.wr_sel  = 1'b0;
            bus.wr_addr = 2'd0;
            bus.wr_data = 32'h55555555;
            ref_a[0]    = 32'h55555555;
        end
        push_run();
        bus.start = 1'b1;
        cyc();
        for (int c = 0; c <= LAST; c++) begin
            bus.start = 1'b0;
            bus.wr_en = 1'b0;
            if (kind == 1) begin
                if (c == 1) chk("cyc1_a", 64'(bus.a_out), 64'h00000000);
                if (c == 1) chk("cyc1_b", 64'(bus.b_out), 64'h00000080);
                if (c == 4) chk("cyc4_a", 64'(bus.a_out), 64'h03122130);
                if (c == 4) chk("cyc4_b", 64'(bus.b_out), 64'h8392A1B0);
                if (c == 7) chk("cyc7_a", 64'(bus.a_out), 64'h33000000);
                if (c == 7) chk("cyc7_b", 64'(bus.b_out), 64'hB3000000);
                if (c == K + 2*N) chk("mode_first_drain", 64'(bus.mode_out), 64'(DRAIN_ON));
                if (c == LAST) chk("done_cycle", 64'(bus.done), 64'd1);
            end
            if (kind == 2) begin
                if (c == 3 || c == 4) begin
                    bus.wr_en   = 1'b1;
                    bus.wr_sel  = (c == 4);
                    bus.wr_addr = 2'd3;
                    bus.wr_data = 32'hFFFFFFFF;
                end
                if (c == 5) bus.start = 1'b1;
            end
            if (kind == 3 && c == 1) chk("same_edge_lane0", 64'(bus.a_out[7:0]), 64'h55);
            cyc();
        end
        bus.start = 1'b0;
        bus.wr_en = 1'b0;
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    initial begin
        rst         = 1'b1;
        bus.wr_en   = 1'b0;
        bus.wr_sel  = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.start   = 1'b0;
        cyc();
        cyc();
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_mode", 64'(bus.mode_out), 64'd0);
        chk("rst_a", 64'(bus.a_out), 64'd0);
        chk("rst_b", 64'(bus.b_out), 64'd0);
        rst = 1'b0;
        cyc();

        for (int k = 0; k < K; k++) begin
            logic [N*W-1:0] va, vb;
            for (int i = 0; i < N; i++) begin
                va[i*W +: W] = 8'(16*k + i);
                vb[i*W +: W] = 8'(8'h80 + 16*k + i);
            end
            write_vec(1'b0, k, va);
            write_vec(1'b1, k, vb);
        end

        do_run(1);   // skew and phase boundaries
        do_run(2);   // dropped writes and ignored start
        do_run(1);   // buffers unchanged by the dropped writes

        // Reset in the middle of STREAM, held two cycles.
        push_run();
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
        cyc();
        cyc();
        cyc();
        rst = 1'b1;
        cyc();
        exp_q.delete();
        chk("midrst_busy", 64'(bus.busy), 64'd0);
        chk("midrst_done", 64'(bus.done), 64'd0);
        chk("midrst_mode", 64'(bus.mode_out), 64'd0);
        chk("midrst_a", 64'(bus.a_out), 64'd0);
        chk("midrst_b", 64'(bus.b_out), 64'd0);
        cyc();
        rst = 1'b0;
        cyc();
        do_run(1);   // identical stream after reset: buffers retained

        do_run(3);   // write on the start edge is used by that run
        do_run(0);   // back-to-back with the updated buffer

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
